ll_head_table_frontend: RTL and testbench
=========================================

Name: ll_head_table_frontend

Overview:
- Upstream stage of the linked-list engine top.
- Accepts key/opcode requests, hashes the key to a bucket and reads that bucket's head pointer from an internal head RAM.
- Issues one command (key, opcode, head_ptr, head_ptr_val) to the linked-list engine, then commits the engine's head-table write-back into the head RAM.
- Exactly one command is outstanding at a time, so the head-pointer state is always coherent with the engine.

Parameters:
- BUCKET_WIDTH, 8, log2 of bucket count; head RAM depth is 2^BUCKET_WIDTH.
- KEY_WIDTH, LL_KEY_WIDTH, request key width.
- PTR_WIDTH, LL_HEAD_PTR_WIDTH, head pointer width.
- TIMEOUT_CYCLES, 1024, wait watchdog limit (used only with the optional feature).

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  asynchronous active-low reset
- req_valid_i  in  1  request valid
- req_ready_o  out  1  request ready
- req_key_i  in  KEY_WIDTH  request key
- req_opcode_i  in  2  request opcode
- ll_cmd_valid_o  out  1  command to engine valid
- ll_cmd_ready_i  in  1  engine accepts command
- ll_cmd_key_o  out  KEY_WIDTH  command key
- ll_cmd_opcode_o  out  2  command opcode
- ll_cmd_head_ptr_o  out  PTR_WIDTH  bucket head pointer
- ll_cmd_head_ptr_val_o  out  1  head pointer valid (bucket non-empty)
- ll_res_valid_i  in  1  engine result valid (snooped)
- ll_res_ready_i  in  1  downstream ready on result (snooped)
- ht_wr_en_i  in  1  engine head write-back strobe (result-aligned)
- ht_wr_data_ptr_i  in  PTR_WIDTH  new head pointer
- ht_wr_data_ptr_val_i  in  1  new head pointer valid
- init_done_o  out  1  head RAM clear complete
- busy_o  out  1  state not IDLE

Behaviour:
- Reset (rst_n_i low, asynchronous): state = INIT, clear address = 0.
  - All outputs 0, except busy_o = 1.
  - Deassertion of rst_n_i is synchronised externally.
- INIT: writes {val=0, ptr=0} to address clear_addr each cycle, incrementing clear_addr.
  - After address 2^BUCKET_WIDTH-1: init_done_o = 1 (sticky until reset), go to IDLE.
  - req_ready_o = 0 throughout INIT.
- Bucket hash: key zero-extended to a multiple of BUCKET_WIDTH, all BUCKET_WIDTH slices XORed together.
- Head RAM: 2^BUCKET_WIDTH x (PTR_WIDTH+1) entries, one write port, one synchronous read port with 1-cycle latency.
- IDLE: req_ready_o = 1.
  - On accept: latch key, opcode and bucket.
  - Opcode is LL_OP_INSERT, LL_OP_DELETE or LL_OP_DEQ: issue RAM read and go to READ.
  - Any other opcode: consume and discard the request, stay in IDLE.
- READ: one cycle; RAM data is registered into the command outputs; go to ISSUE.
- ISSUE: ll_cmd_valid_o = 1 with stable payload until ll_cmd_ready_i; on handshake go to WAIT.
  - Latency: accept at cycle t gives ll_cmd_valid_o at t+2.
- WAIT: on ht_wr_en_i, write {ht_wr_data_ptr_val_i, ht_wr_data_ptr_i} to the latched bucket.
  - Result fire (ll_res_valid_i && ll_res_ready_i) returns the block to IDLE.
  - Write-back and result fire in the same cycle: both are applied.
  - Result fire without any write-back: RAM unchanged (e.g. a delete miss).
- Back-to-back requests: a write at cycle w and a read at w+1 or later need no bypass.
  - A read in the same cycle as a write cannot occur, because only one command is outstanding.
- ht_wr_en_i outside WAIT is ignored.
- ll_res_valid_i outside WAIT is ignored.
- Reset mid-operation: the outstanding command is abandoned and the RAM is re-cleared.
  - The engine must be reset concurrently.

Optional Feature:
- Macro LL_HT_TIMEOUT_EN.
- Defined:
  - A wait counter runs in WAIT.
  - Reaching TIMEOUT_CYCLES without result fire: return to IDLE, RAM unchanged, sticky output err_timeout_o = 1 until reset.
  - The counter clears on entry to WAIT.
- Undefined: no counter, no err_timeout_o port; WAIT lasts indefinitely.

Decomposition:
- Package linked_list holds LL_KEY_WIDTH, LL_HEAD_PTR_WIDTH and the opcode constants LL_OP_INSERT, LL_OP_DELETE, LL_OP_DEQ.
- New package additions:
  - typedef ll_head_entry_t {val, ptr}
  - enum ll_ht_fe_state_t {INIT, IDLE, READ, ISSUE, WAIT}
- Sub-module ll_head_ram: simple dual-port RAM, 1-cycle registered read.

Test Plan (all scenarios with BUCKET_WIDTH = 4):
- Reset then idle -> init_done_o rises after exactly 16 INIT cycles; req_ready_o is 0 until then.
- INSERT key 0x12 into an empty bucket -> ll_cmd_head_ptr_val_o = 0 at t+2. Drive ht_wr_en_i with ptr 5, val 1, then result fire -> next INSERT to the same bucket shows head_ptr = 5, val = 1.
- DELETE on bucket 3 with result fire but no ht_wr_en_i -> bucket 3 keeps its prior {1,5}.
- ll_cmd_ready_i held low for 7 cycles -> payload stable, single handshake, req_ready_o = 0 throughout.
- Opcode not INSERT/DELETE/DEQ -> consumed in one cycle, no ll_cmd_valid_o, busy_o stays 0.
- With LL_HT_TIMEOUT_EN, TIMEOUT_CYCLES = 8 and no result -> IDLE after 8 WAIT cycles, err_timeout_o = 1. Assert rst_n_i in WAIT -> outputs reset immediately, INIT restarts.

Source files
------------

// File: rtl/ll_head_table_frontend_pkg.sv
// Shared linked-list definitions: key/pointer widths, opcodes, head-table
// entry layout and the head-table front-end state encoding.
package linked_list;

   localparam int LL_KEY_WIDTH      = 16;
   localparam int LL_HEAD_PTR_WIDTH = 10;

   localparam logic [1:0] LL_OP_INSERT = 2'd0;
   localparam logic [1:0] LL_OP_DELETE = 2'd1;
   localparam logic [1:0] LL_OP_DEQ    = 2'd2;

   // One head RAM entry: val marks a non-empty bucket.
   typedef struct packed {
      logic                         val;
      logic [LL_HEAD_PTR_WIDTH-1:0] ptr;
   } ll_head_entry_t;

   typedef enum logic [2:0] {
      INIT,
      IDLE,
      READ,
      ISSUE,
      WAIT
   } ll_ht_fe_state_t;

   // True for the opcodes that need the engine; anything else is dropped.
   function automatic logic ll_op_is_cmd(input logic [1:0] op);
      return (op == LL_OP_INSERT) || (op == LL_OP_DELETE) || (op == LL_OP_DEQ);
   endfunction

endpackage

// File: rtl/ll_head_table_frontend_ram.sv
// Head pointer RAM: one write port, one read port with a registered
// (1-cycle) read. No reset on the array; the front-end clears it in INIT.
module ll_head_ram #(
   parameter int ADDR_WIDTH = 8,
   parameter int DATA_WIDTH = 11
) (
   input  logic                  clk_i,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic                  rd_en_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   logic [DATA_WIDTH-1:0] r_mem [2**ADDR_WIDTH];

   // Write port.
   always_ff @(posedge clk_i) begin
      if (wr_en_i) r_mem[wr_addr_i] <= wr_data_i;
   end

   // Registered read port.
   always_ff @(posedge clk_i) begin
      if (rd_en_i) rd_data_o <= r_mem[rd_addr_i];
   end

endmodule

// File: rtl/ll_head_table_frontend.sv
// Head-table front-end of the linked-list engine. Hashes request keys to a
// bucket, reads the bucket head, issues one command to the engine and commits
// the engine's head write-back. Only one command is ever outstanding.
// Optional wait watchdog (err_timeout_o) enabled by LL_HT_TIMEOUT_EN.
//
// Handshakes: a transfer happens on a rising clock edge where valid and ready
// are both high; while valid is high and ready is low the payload holds.
module ll_head_table_frontend
   import linked_list::*;
#(
   parameter int BUCKET_WIDTH   = 8,
   parameter int KEY_WIDTH      = LL_KEY_WIDTH,
   parameter int PTR_WIDTH      = LL_HEAD_PTR_WIDTH
`ifdef LL_HT_TIMEOUT_EN
   ,parameter int TIMEOUT_CYCLES = 1024
`endif
) (
   input  logic                 clk_i,
   input  logic                 rst_n_i,
   input  logic                 req_valid_i,
   output logic                 req_ready_o,
   input  logic [KEY_WIDTH-1:0] req_key_i,
   input  logic [1:0]           req_opcode_i,
   output logic                 ll_cmd_valid_o,
   input  logic                 ll_cmd_ready_i,
   output logic [KEY_WIDTH-1:0] ll_cmd_key_o,
   output logic [1:0]           ll_cmd_opcode_o,
   output logic [PTR_WIDTH-1:0] ll_cmd_head_ptr_o,
   output logic                 ll_cmd_head_ptr_val_o,
   input  logic                 ll_res_valid_i,
   input  logic                 ll_res_ready_i,
   input  logic                 ht_wr_en_i,
   input  logic [PTR_WIDTH-1:0] ht_wr_data_ptr_i,
   input  logic                 ht_wr_data_ptr_val_i,
   output logic                 init_done_o,
`ifdef LL_HT_TIMEOUT_EN
   output logic                 err_timeout_o,
`endif
   output ll_ht_fe_state_t      dbg_state_o,
   output logic                 busy_o
);

   localparam int NSLICE = (KEY_WIDTH + BUCKET_WIDTH - 1) / BUCKET_WIDTH;
   localparam int EXT_W  = NSLICE * BUCKET_WIDTH;

   ll_head_entry_t r_unused_entry_layout_ref; // layout reference only
   assign r_unused_entry_layout_ref = '0;

   ll_ht_fe_state_t          r_state, w_next_state;
   logic [BUCKET_WIDTH-1:0]  r_clear_addr;
   logic                     r_init_done;
   logic [KEY_WIDTH-1:0]     r_key;
   logic [1:0]               r_opcode;
   logic [BUCKET_WIDTH-1:0]  r_bucket;
   logic [PTR_WIDTH-1:0]     r_head_ptr;
   logic                     r_head_val;

   logic [EXT_W-1:0]         w_key_ext;
   logic [BUCKET_WIDTH-1:0]  w_bucket;
   logic                     w_accept;
   logic                     w_rd_en;
   logic                     w_wr_en;
   logic [BUCKET_WIDTH-1:0]  w_wr_addr;
   logic [PTR_WIDTH:0]       w_wr_data;
   logic [PTR_WIDTH:0]       w_rd_data;
   logic                     w_res_fire;

   assign w_res_fire = ll_res_valid_i && ll_res_ready_i;

   // Bucket hash: zero-extend the key and XOR-fold it into BUCKET_WIDTH bits.
   always_comb begin
      w_key_ext = EXT_W'(req_key_i);
      w_bucket  = '0;
      for (int i = 0; i < NSLICE; i++) begin
         w_bucket = w_bucket ^ w_key_ext[i*BUCKET_WIDTH +: BUCKET_WIDTH];
      end
   end

`ifdef LL_HT_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   logic [CNT_W-1:0] r_wait_cnt;
   logic             r_err_timeout;
   logic             w_timeout;
`endif

   // State register.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= INIT;
      else          r_state <= w_next_state;
   end

   // Next state plus RAM port control.
   always_comb begin
      w_next_state = r_state;
      w_accept     = 1'b0;
      w_rd_en      = 1'b0;
      w_wr_en      = 1'b0;
      w_wr_addr    = r_bucket;
      w_wr_data    = '0;
`ifdef LL_HT_TIMEOUT_EN
      w_timeout    = 1'b0;
`endif
      case (r_state)
         INIT: begin
            w_wr_en   = 1'b1;
            w_wr_addr = r_clear_addr;
            if (r_clear_addr == '1) w_next_state = IDLE;
         end
         IDLE: begin
            if (req_valid_i) begin
               w_accept = 1'b1;
               if (ll_op_is_cmd(req_opcode_i)) begin
                  w_rd_en      = 1'b1;
                  w_next_state = READ;
               end
            end
         end
         READ: w_next_state = ISSUE;
         ISSUE: begin
            if (ll_cmd_ready_i) w_next_state = WAIT;
         end
         WAIT: begin
            if (ht_wr_en_i) begin
               w_wr_en   = 1'b1;
               w_wr_data = {ht_wr_data_ptr_val_i, ht_wr_data_ptr_i};
            end
            if (w_res_fire) begin
               w_next_state = IDLE;
            end
`ifdef LL_HT_TIMEOUT_EN
            else if (r_wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
               w_next_state = IDLE;
               w_timeout    = 1'b1;
            end
`endif
         end
         default: w_next_state = INIT;
      endcase
   end

   // Clear sweep, request latch and command payload registers.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_clear_addr <= '0;
         r_init_done  <= 1'b0;
         r_key        <= '0;
         r_opcode     <= '0;
         r_bucket     <= '0;
         r_head_ptr   <= '0;
         r_head_val   <= 1'b0;
      end else begin
         if (r_state == INIT) begin
            r_clear_addr <= r_clear_addr + BUCKET_WIDTH'(1);
            if (r_clear_addr == '1) r_init_done <= 1'b1;
         end
         if (w_accept) begin
            r_key    <= req_key_i;
            r_opcode <= req_opcode_i;
            r_bucket <= w_bucket;
         end
         if (r_state == READ) begin
            {r_head_val, r_head_ptr} <= w_rd_data;
         end
      end
   end

`ifdef LL_HT_TIMEOUT_EN
   // Wait watchdog: cleared while issuing, counts every WAIT cycle.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_wait_cnt    <= '0;
         r_err_timeout <= 1'b0;
      end else begin
         if (r_state == ISSUE)     r_wait_cnt <= '0;
         else if (r_state == WAIT) r_wait_cnt <= r_wait_cnt + CNT_W'(1);
         if (w_timeout) r_err_timeout <= 1'b1;
      end
   end

   assign err_timeout_o = r_err_timeout;
`endif

   ll_head_ram #(
      .ADDR_WIDTH (BUCKET_WIDTH),
      .DATA_WIDTH (PTR_WIDTH + 1)
   ) u_head_ram (
      .clk_i     (clk_i),
      .wr_en_i   (w_wr_en),
      .wr_addr_i (w_wr_addr),
      .wr_data_i (w_wr_data),
      .rd_en_i   (w_rd_en),
      .rd_addr_i (w_bucket),
      .rd_data_o (w_rd_data)
   );

   assign req_ready_o           = (r_state == IDLE);
   assign ll_cmd_valid_o        = (r_state == ISSUE);
   assign ll_cmd_key_o          = r_key;
   assign ll_cmd_opcode_o       = r_opcode;
   assign ll_cmd_head_ptr_o     = r_head_ptr;
   assign ll_cmd_head_ptr_val_o = r_head_val;
   assign init_done_o           = r_init_done;
   assign busy_o                = (r_state != IDLE);
   assign dbg_state_o           = r_state;

endmodule

// File: tb/tb_ll_head_table_frontend.sv
// Self-checking bench for ll_head_table_frontend with a 16-bucket head table.
// Also covers the wait watchdog when LL_HT_TIMEOUT_EN is defined.
module tb_ll_head_table_frontend;
   import linked_list::*;

   localparam int BW = 4;
   localparam int KW = LL_KEY_WIDTH;
   localparam int PW = LL_HEAD_PTR_WIDTH;
   localparam int W  = KW + 2 + 1 + PW;

   logic          clk;
   logic          rst_n;
   logic          req_valid;
   logic          req_ready;
   logic [KW-1:0] req_key;
   logic [1:0]    req_opcode;
   logic          cmd_valid;
   logic          cmd_ready;
   logic [KW-1:0] cmd_key;
   logic [1:0]    cmd_opcode;
   logic [PW-1:0] cmd_ptr;
   logic          cmd_ptr_val;
   logic          res_valid;
   logic          res_ready;
   logic          wr_en;
   logic [PW-1:0] wr_ptr;
   logic          wr_val;
   logic          init_done;
   logic          busy;
   ll_ht_fe_state_t dbg_state;
`ifdef LL_HT_TIMEOUT_EN
   logic          err_timeout;
`endif

   int checks   = 0;
   int failures = 0;
   logic [W-1:0] exp_q[$];
   ll_head_entry_t model_ram [16];

   // Clock and watchdog.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "timeout");
   end

   ll_head_table_frontend #(
      .BUCKET_WIDTH (BW)
`ifdef LL_HT_TIMEOUT_EN
      ,.TIMEOUT_CYCLES (8)
`endif
   ) dut (
      .clk_i                 (clk),
      .rst_n_i               (rst_n),
      .req_valid_i           (req_valid),
      .req_ready_o           (req_ready),
      .req_key_i             (req_key),
      .req_opcode_i          (req_opcode),
      .ll_cmd_valid_o        (cmd_valid),
      .ll_cmd_ready_i        (cmd_ready),
      .ll_cmd_key_o          (cmd_key),
      .ll_cmd_opcode_o       (cmd_opcode),
      .ll_cmd_head_ptr_o     (cmd_ptr),
      .ll_cmd_head_ptr_val_o (cmd_ptr_val),
      .ll_res_valid_i        (res_valid),
      .ll_res_ready_i        (res_ready),
      .ht_wr_en_i            (wr_en),
      .ht_wr_data_ptr_i      (wr_ptr),
      .ht_wr_data_ptr_val_i  (wr_val),
      .init_done_o           (init_done),
`ifdef LL_HT_TIMEOUT_EN
      .err_timeout_o         (err_timeout),
`endif
      .dbg_state_o           (dbg_state),
      .busy_o                (busy)
   );

   // Reference hash: XOR of the four key nibbles.
   function automatic logic [3:0] tb_bucket(input logic [15:0] k);
      return k[3:0] ^ k[7:4] ^ k[11:8] ^ k[15:12];
   endfunction

   function automatic logic [W-1:0] exp_payload(input logic [KW-1:0] k, input logic [1:0] op);
      ll_head_entry_t e;
      e = model_ram[tb_bucket(k)];
      return {k, op, e.val, e.ptr};
   endfunction

   function automatic logic [W-1:0] cur_payload();
      return {cmd_key, cmd_opcode, cmd_ptr_val, cmd_ptr};
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 16; i++) model_ram[i] = '0;
   endtask

   // Driver: present one request and hold it until accepted.
   task automatic drive_req(input logic [KW-1:0] k, input logic [1:0] op, output bit timed_out);
      int n;
      n = 0;
      timed_out = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_key = k; req_opcode = op;
      while (req_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) timed_out = 1'b1;
      @(posedge clk); #1;
      req_valid = 1'b0;
   endtask

   // Driver: count negedges after acceptance until the command shows up.
   task automatic wait_cmd(input int max_wait, output int lat, output logic [W-1:0] got, output bit timed_out);
      lat = 0;
      timed_out = 1'b0;
      got = '0;
      forever begin
         @(negedge clk);
         lat++;
         if (cmd_valid === 1'b1) begin
            got = cur_payload();
            break;
         end
         if (lat >= max_wait) begin
            timed_out = 1'b1;
            break;
         end
      end
   endtask

   // Driver: complete one command handshake after a number of stall cycles.
   task automatic do_txn(input logic [KW-1:0] k, input logic [1:0] op, input int stall,
                         output int lat, output logic [W-1:0] got, output bit timed_out);
      bit t1, t2;
      drive_req(k, op, t1);
      wait_cmd(10, lat, got, t2);
      timed_out = t1 | t2;
      if (!timed_out) begin
         repeat (stall) @(negedge clk);
         cmd_ready = 1'b1;
         @(posedge clk); #1;
         cmd_ready = 1'b0;
      end
   endtask

   // Driver: engine write-back (optionally in the result cycle) and result fire.
   task automatic finish_wait(input logic [3:0] b, input bit wb, input bit same,
                              input logic [PW-1:0] p, input logic v);
      if (wb && !same) begin
         @(negedge clk);
         wr_en = 1'b1; wr_ptr = p; wr_val = v;
         @(posedge clk); #1;
         wr_en = 1'b0;
      end
      @(negedge clk);
      res_valid = 1'b1; res_ready = 1'b1;
      if (wb && same) begin
         wr_en = 1'b1; wr_ptr = p; wr_val = v;
      end
      @(posedge clk); #1;
      res_valid = 1'b0; res_ready = 1'b0; wr_en = 1'b0;
      if (wb) begin
         model_ram[b].val = v;
         model_ram[b].ptr = p;
      end
   endtask

   // Reset and the INIT clear sweep.
   task automatic test_reset();
      int n;
      bit early_ready;
      logic [W+3:0] obs;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      obs = {busy, req_ready, cmd_valid, init_done, cur_payload()};
      checks++;
      if (obs !== {1'b1, {(W+3){1'b0}}})
         $display("FAIL reset_outputs got=%h exp=%h", obs, {1'b1, {(W+3){1'b0}}});
      if (obs !== {1'b1, {(W+3){1'b0}}}) failures++;
      rst_n = 1'b1;
      n = 0;
      early_ready = 1'b0;
      while (init_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
         if (init_done !== 1'b1 && req_ready !== 1'b0) early_ready = 1'b1;
      end
      checks++;
      if (n != 16) begin
         $display("FAIL init_cycles got=%0d exp=16", n);
         failures++;
      end
      checks++;
      if (early_ready) begin
         $display("FAIL init_ready got=1 exp=0 before init_done");
         failures++;
      end
      checks++;
      if ({req_ready, busy} !== 2'b10) begin
         $display("FAIL idle_after_init got=%b exp=10", {req_ready, busy});
         failures++;
      end
      model_clear();
   endtask

   // INSERT into an empty bucket, write-back, then re-read the bucket.
   task automatic test_insert();
      int lat;
      logic [W-1:0] got, e;
      bit to;
      exp_q.push_back(exp_payload(16'h0012, LL_OP_INSERT));
      do_txn(16'h0012, LL_OP_INSERT, 0, lat, got, to);
      e = exp_q.pop_front();
      checks++;
      if (to || lat != 2) begin
         $display("FAIL insert_latency got=%0d timeout=%0d exp=2", lat, to);
         failures++;
      end
      checks++;
      if (got !== e) begin
         $display("FAIL insert_empty_payload got=%h exp=%h", got, e);
         failures++;
      end
      finish_wait(4'd3, 1'b1, 1'b0, 10'd5, 1'b1);
      @(negedge clk);
      checks++;
      if (busy !== 1'b0) begin
         $display("FAIL insert_back_to_idle busy got=%b exp=0", busy);
         failures++;
      end
      exp_q.push_back(exp_payload(16'h0012, LL_OP_INSERT));
      do_txn(16'h0012, LL_OP_INSERT, 1, lat, got, to);
      e = exp_q.pop_front();
      checks++;
      if (to || got !== e) begin
         $display("FAIL insert_reread got=%h exp=%h timeout=%0d", got, e, to);
         failures++;
      end
      finish_wait(4'd3, 1'b0, 1'b0, '0, 1'b0);
   endtask

   // DELETE miss: result fire with no write-back leaves the bucket untouched.
   task automatic test_delete_miss();
      int lat;
      logic [W-1:0] got, e;
      bit to;
      exp_q.push_back(exp_payload(16'h0030, LL_OP_DELETE));
      do_txn(16'h0030, LL_OP_DELETE, 0, lat, got, to);
      e = exp_q.pop_front();
      checks++;
      if (to || got !== e) begin
         $display("FAIL delete_payload got=%h exp=%h timeout=%0d", got, e, to);
         failures++;
      end
      finish_wait(4'd3, 1'b0, 1'b0, '0, 1'b0);
      exp_q.push_back(exp_payload(16'h0300, LL_OP_DEQ));
      do_txn(16'h0300, LL_OP_DEQ, 0, lat, got, to);
      e = exp_q.pop_front();
      checks++;
      if (to || got !== e) begin
         $display("FAIL delete_miss_kept got=%h exp=%h timeout=%0d", got, e, to);
         failures++;
      end
      finish_wait(4'd3, 1'b0, 1'b0, '0, 1'b0);
   endtask

   // Write-back in the same cycle as result fire must still be committed.
   task automatic test_same_cycle();
      int lat;
      logic [W-1:0] got, e;
      bit to;
      exp_q.push_back(exp_payload(16'h0003, LL_OP_DEQ));
      do_txn(16'h0003, LL_OP_DEQ, 0, lat, got, to);
      e = exp_q.pop_front();
      checks++;
      if (to || got !== e) begin
         $display("FAIL same_cycle_first got=%h exp=%h", got, e);
         failures++;
      end
      finish_wait(4'd3, 1'b1, 1'b1, 10'h02A, 1'b1);
      exp_q.push_back(exp_payload(16'h3000, LL_OP_INSERT));
      do_txn(16'h3000, LL_OP_INSERT, 0, lat, got, to);
      e = exp_q.pop_front();
      checks++;
      if (to || got !== e) begin
         $display("FAIL same_cycle_committed got=%h exp=%h", got, e);
         failures++;
      end
      finish_wait(4'd3, 1'b0, 1'b0, '0, 1'b0);
   endtask

   // Engine back-pressure for 7 cycles; stray write-back/result are ignored.
   task automatic test_backpressure();
      int lat;
      logic [W-1:0] got, e;
      bit to;
      e = exp_payload(16'h00A5, LL_OP_INSERT);
      drive_req(16'h00A5, LL_OP_INSERT, to);
      wait_cmd(10, lat, got, to);
      for (int i = 0; i < 7; i++) begin
         checks++;
         if ({cmd_valid, req_ready} !== 2'b10 || cur_payload() !== e) begin
            $display("FAIL stall_cycle_%0d valid_ready=%b payload=%h exp=10 %h",
                     i, {cmd_valid, req_ready}, cur_payload(), e);
            failures++;
         end
         wr_en = (i == 2); wr_ptr = 10'h3FF; wr_val = 1'b1;
         res_valid = (i == 4); res_ready = (i == 4);
         @(negedge clk);
      end
      wr_en = 1'b0; res_valid = 1'b0; res_ready = 1'b0;
      cmd_ready = 1'b1;
      @(posedge clk); #1;
      cmd_ready = 1'b0;
      @(negedge clk);
      checks++;
      if ({cmd_valid, busy, req_ready} !== 3'b010) begin
         $display("FAIL single_handshake got=%b exp=010", {cmd_valid, busy, req_ready});
         failures++;
      end
      finish_wait(4'hF, 1'b0, 1'b0, '0, 1'b0);
      exp_q.push_back(exp_payload(16'h00A5, LL_OP_DEQ));
      do_txn(16'h00A5, LL_OP_DEQ, 0, lat, got, to);
      e = exp_q.pop_front();
      checks++;
      if (to || got !== e) begin
         $display("FAIL stray_wb_ignored got=%h exp=%h", got, e);
         failures++;
      end
      finish_wait(4'hF, 1'b0, 1'b0, '0, 1'b0);
   endtask

   // Unknown opcode is consumed without a command.
   task automatic test_bad_opcode();
      bit to;
      drive_req(16'h1234, 2'd3, to);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         checks++;
         if (to || {cmd_valid, busy, req_ready} !== 3'b001) begin
            $display("FAIL bad_opcode_cycle_%0d got=%b exp=001", i, {cmd_valid, busy, req_ready});
            failures++;
         end
      end
   endtask

   // Random mix of commands, write-backs and stalls against the bucket model.
   task automatic test_random();
      int lat;
      logic [W-1:0] got, e;
      logic [KW-1:0] k;
      logic [1:0] op;
      bit to, wb, same;
      for (int i = 0; i < 24; i++) begin
         k    = KW'($urandom_range(0, 65535));
         op   = 2'($urandom_range(0, 2));
         wb   = 1'($urandom_range(0, 1));
         same = 1'($urandom_range(0, 1));
         exp_q.push_back(exp_payload(k, op));
         do_txn(k, op, $urandom_range(0, 3), lat, got, to);
         e = exp_q.pop_front();
         checks++;
         if (to || lat != 2 || got !== e) begin
            $display("FAIL random_%0d got=%h lat=%0d exp=%h lat=2", i, got, lat, e);
            failures++;
         end
         finish_wait(tb_bucket(k), wb, same, PW'($urandom_range(0, 1023)), 1'($urandom_range(0, 1)));
      end
   endtask

`ifdef LL_HT_TIMEOUT_EN
   // Missing result: watchdog returns to IDLE after 8 WAIT cycles.
   task automatic test_timeout();
      int lat, n;
      logic [W-1:0] got, e;
      bit to;
      do_txn(16'h0077, LL_OP_INSERT, 0, lat, got, to);
      n = 0;
      forever begin
         @(negedge clk);
         if (busy !== 1'b1 || n >= 50) break;
         n++;
      end
      checks++;
      if (n != 8 || err_timeout !== 1'b1) begin
         $display("FAIL timeout got_cycles=%0d err=%b exp=8 1", n, err_timeout);
         failures++;
      end
      exp_q.push_back(exp_payload(16'h0077, LL_OP_DEQ));
      do_txn(16'h0077, LL_OP_DEQ, 0, lat, got, to);
      e = exp_q.pop_front();
      checks++;
      if (to || got !== e) begin
         $display("FAIL timeout_ram_kept got=%h exp=%h", got, e);
         failures++;
      end
      finish_wait(tb_bucket(16'h0077), 1'b0, 1'b0, '0, 1'b0);
   endtask
`endif

   // Asynchronous reset while waiting on the engine re-clears the table.
   task automatic test_reset_mid();
      int lat, n;
      logic [W-1:0] got, e;
      bit to;
      do_txn(16'h0012, LL_OP_INSERT, 0, lat, got, to);
      finish_wait(4'd3, 1'b1, 1'b0, 10'h155, 1'b1);
      do_txn(16'h0012, LL_OP_INSERT, 0, lat, got, to);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if ({busy, req_ready, cmd_valid, init_done} !== 4'b1000) begin
         $display("FAIL reset_mid_outputs got=%b exp=1000", {busy, req_ready, cmd_valid, init_done});
         failures++;
      end
`ifdef LL_HT_TIMEOUT_EN
      checks++;
      if (err_timeout !== 1'b0) begin
         $display("FAIL reset_mid_err got=%b exp=0", err_timeout);
         failures++;
      end
`endif
      @(negedge clk);
      rst_n = 1'b1;
      n = 0;
      while (init_done !== 1'b1 && n < 100) begin
         @(negedge clk);
         n++;
      end
      checks++;
      if (n != 16) begin
         $display("FAIL reset_mid_init got=%0d exp=16", n);
         failures++;
      end
      model_clear();
      exp_q.push_back(exp_payload(16'h0012, LL_OP_INSERT));
      do_txn(16'h0012, LL_OP_INSERT, 0, lat, got, to);
      e = exp_q.pop_front();
      checks++;
      if (to || got !== e) begin
         $display("FAIL reset_mid_cleared got=%h exp=%h", got, e);
         failures++;
      end
      finish_wait(4'd3, 1'b0, 1'b0, '0, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0; req_valid = 1'b0; req_key = '0; req_opcode = '0;
      cmd_ready = 1'b0; res_valid = 1'b0; res_ready = 1'b0;
      wr_en = 1'b0; wr_ptr = '0; wr_val = 1'b0;
      model_clear();
      test_reset();
      test_insert();
      test_delete_miss();
      test_same_cycle();
      test_backpressure();
      test_bad_opcode();
      test_random();
`ifdef LL_HT_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
